// File: rtl/ram_responder_if.sv
// ram_responder_if: request/response bundle between the pipeline stages (master)
// and the RAM responder (slave). Optional byte strobes exist only when
// RAM_RESPONDER_BYTE_EN is defined.
interface ram_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_address;
    logic [DATA_WIDTH-1:0]   req_wdata;
`ifdef RAM_RESPONDER_BYTE_EN
    logic [DATA_WIDTH/8-1:0] req_wstrb;
`endif
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_error;

    modport master (
        output req_valid, req_write, req_address, req_wdata,
`ifdef RAM_RESPONDER_BYTE_EN
        output req_wstrb,
`endif
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_address, req_wdata,
`ifdef RAM_RESPONDER_BYTE_EN
        input  req_wstrb,
`endif
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: memory-side end of the pipeline RAM port. Accepts one read or
// write per valid/ready handshake, waits WAIT_CYCLES, then performs the access
// on the internal word-addressed RAM and pulses resp_valid for one cycle.
// Optional feature macro: RAM_RESPONDER_BYTE_EN (per-byte write strobes).
// Timing from the accept edge E0: the access and resp_valid rise happen at edge
// E0+WAIT_CYCLES+1; req_ready is back up during the response cycle, giving one
// transaction every WAIT_CYCLES+2 cycles.
module ram_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 10,   // must not exceed ADDR_WIDTH
    parameter int WAIT_CYCLES = 1     // 0..15
) (
    input  logic            clk,
    input  logic            reset_n,
    ram_responder_if.slave  bus
);
    localparam int DEPTH  = 2 ** DEPTH_LOG2;
    localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]    CNT_LOAD    = CNT_W'(WAIT_CYCLES);
    // Full-width bound so high address bits are compared, never truncated.
    localparam logic [ADDR_WIDTH:0] DEPTH_WORDS = (ADDR_WIDTH + 1)'(DEPTH);
`ifdef RAM_RESPONDER_BYTE_EN
    localparam int NBYTES = DATA_WIDTH / 8;
`endif

    // S_RESP is the access cycle; the registered outputs show its result one cycle later.
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
`ifdef RAM_RESPONDER_BYTE_EN
    logic [NBYTES-1:0]       wstrb_q, wstrb_d;
`endif
    logic                    ready_q, ready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_error_q, resp_error_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    in_range;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [DATA_WIDTH-1:0]   merged;
    logic                    commit;

    // Decode the captured address and build the word that a write would store.
    always_comb begin
        in_range = ({1'b0, addr_q} < DEPTH_WORDS);
        idx      = addr_q[DEPTH_LOG2-1:0];
`ifdef RAM_RESPONDER_BYTE_EN
        merged = mem[idx];
        for (int b = 0; b < NBYTES; b++) begin
            if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
        end
`else
        merged = wdata_q;
`endif
    end

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
`ifdef RAM_RESPONDER_BYTE_EN
        wstrb_d      = wstrb_q;
`endif
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        commit       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_address;
                    wdata_d = bus.req_wdata;
`ifdef RAM_RESPONDER_BYTE_EN
                    wstrb_d = bus.req_wstrb;
`endif
                    cnt_d   = CNT_LOAD;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b1;
                resp_error_d = !in_range;
                commit       = write_q && in_range;
                if (!write_q) resp_rdata_d = in_range ? mem[idx] : '0;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs; reset discards any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
`ifdef RAM_RESPONDER_BYTE_EN
            wstrb_q      <= '0;
`endif
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
`ifdef RAM_RESPONDER_BYTE_EN
            wstrb_q      <= wstrb_d;
`endif
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // RAM write port, committed at the end of the access cycle.
    // NOTE: the array has no reset so it maps onto RAM macros; contents survive reset_n.
    always_ff @(posedge clk) begin
        if (commit) mem[idx] <= merged;
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_error = resp_error_q;
    assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed test of ram_responder with two instances,
// WAIT_CYCLES=1 (sel=0) and WAIT_CYCLES=0 (sel=1), sharing one request driver.
module tb_ram_responder;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic            sel;
    logic            req_valid;
    logic            req_write;
    logic [AW-1:0]   req_address;
    logic [DW-1:0]   req_wdata;
    logic [DW/8-1:0] req_wstrb;

    ram_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    ram_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

    assign bus1.req_valid   = req_valid && !sel;
    assign bus0.req_valid   = req_valid && sel;
    assign bus1.req_write   = req_write;
    assign bus0.req_write   = req_write;
    assign bus1.req_address = req_address;
    assign bus0.req_address = req_address;
    assign bus1.req_wdata   = req_wdata;
    assign bus0.req_wdata   = req_wdata;
`ifdef RAM_RESPONDER_BYTE_EN
    assign bus1.req_wstrb   = req_wstrb;
    assign bus0.req_wstrb   = req_wstrb;
`endif

    logic          ready, resp_valid, resp_error;
    logic [DW-1:0] resp_rdata;
    assign ready      = sel ? bus0.req_ready  : bus1.req_ready;
    assign resp_valid = sel ? bus0.resp_valid : bus1.resp_valid;
    assign resp_error = sel ? bus0.resp_error : bus1.resp_error;
    assign resp_rdata = sel ? bus0.resp_rdata : bus1.resp_rdata;

    ram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(10), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );
    ram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One handshake; lat counts posedges after the accept edge until resp_valid is seen (-1 = none).
    task automatic txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW/8-1:0] s, output int lat, output logic rdy_after,
                       output logic [DW-1:0] rd, output logic er, output logic vld_after,
                       output logic er_after);
        int n;
        lat = -1; rd = '0; er = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_write = wr; req_address = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rdy_after = ready;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        rd = resp_rdata;
        er = resp_error;
        @(negedge clk);
        vld_after = resp_valid;
        er_after  = resp_error;
    endtask

    int            lat;
    logic          rdy_after, er, vld_after, er_after;
    logic [DW-1:0] rd;
    int            acc [$];
    int            pulses;

    initial begin
        sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_address = '0;
        req_wdata = '0; req_wstrb = '1; reset_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready_w1", bus1.req_ready, 0);
        check("rst_valid_w1", bus1.resp_valid, 0);
        check("rst_rdata_w1", bus1.resp_rdata, 0);
        check("rst_error_w1", bus1.resp_error, 0);
        check("rst_ready_w0", bus0.req_ready, 0);
        reset_n = 1'b1;
        #1 check("ready_before_edge", bus1.req_ready, 0);
        @(negedge clk);
        check("ready_after_rst_w1", bus1.req_ready, 1);
        check("ready_after_rst_w0", bus0.req_ready, 1);

        // WAIT_CYCLES=1: write then read addr 20
        txn(1'b1, 16'd20, 32'd1099, '1, lat, rdy_after, rd, er, vld_after, er_after);
        check("w20_latency", lat, 2);
        check("w20_ready_busy", rdy_after, 0);
        check("w20_error", er, 0);
        check("w20_rdata_kept", rd, 0);
        check("w20_pulse_width", vld_after, 0);
        txn(1'b0, 16'd20, 32'd0, '1, lat, rdy_after, rd, er, vld_after, er_after);
        check("r20_latency", lat, 2);
        check("r20_ready_busy", rdy_after, 0);
        check("r20_rdata", rd, 1099);
        check("r20_error", er, 0);

        // Range boundary and aliasing
        txn(1'b1, 16'h03FF, 32'h1234, '1, lat, rdy_after, rd, er, vld_after, er_after);
        check("w3ff_error", er, 0);
        txn(1'b0, 16'd1024, 32'd0, '1, lat, rdy_after, rd, er, vld_after, er_after);
        check("r1024_latency", lat, 2);
        check("r1024_error", er, 1);
        check("r1024_rdata", rd, 0);
        check("r1024_error_after", er_after, 0);
        txn(1'b1, 16'hFFFF, 32'd5, '1, lat, rdy_after, rd, er, vld_after, er_after);
        check("wffff_error", er, 1);
        check("wffff_rdata_kept", rd, 0);
        txn(1'b0, 16'h03FF, 32'd0, '1, lat, rdy_after, rd, er, vld_after, er_after);
        check("r3ff_no_alias", rd, 32'h1234);
        check("r3ff_error", er, 0);

        // WAIT_CYCLES=0
        sel = 1'b1;
        txn(1'b1, 16'd84, 32'hCAFE, '1, lat, rdy_after, rd, er, vld_after, er_after);
        check("w84_latency", lat, 1);
        check("w84_ready_busy", rdy_after, 0);
        txn(1'b0, 16'd84, 32'd0, '1, lat, rdy_after, rd, er, vld_after, er_after);
        check("r84_latency", lat, 1);
        check("r84_rdata", rd, 32'hCAFE);
        check("r84_pulse_width", vld_after, 0);

        // req_valid held high: accepts every 2 cycles
        @(negedge clk);
        req_write = 1'b0; req_address = 16'd84; req_valid = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            if (resp_valid) pulses++;
            if (ready) acc.push_back(k);
        end
        req_valid = 1'b0;
        check("held_accepts", acc.size(), 5);
        if (acc.size() >= 3) begin
            check("held_gap1", acc[1] - acc[0], 2);
            check("held_gap2", acc[2] - acc[1], 2);
        end
        check("held_resp_pulses", pulses, 4);
        repeat (3) @(negedge clk);

        // Reset during WAIT discards the write
        sel = 1'b0;
        txn(1'b1, 16'd10, 32'd3, '1, lat, rdy_after, rd, er, vld_after, er_after);
        check("w10_error", er, 0);
        @(negedge clk);
        req_write = 1'b1; req_address = 16'd10; req_wdata = 32'd7; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1 check("rst_mid_valid", bus1.resp_valid, 0);
        check("rst_mid_ready", bus1.req_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus1.resp_valid) pulses++;
        end
        check("rst_mid_no_resp", pulses, 0);
        txn(1'b0, 16'd10, 32'd0, '1, lat, rdy_after, rd, er, vld_after, er_after);
        check("r10_after_rst", rd, 3);

`ifdef RAM_RESPONDER_BYTE_EN
        // Byte strobes
        txn(1'b1, 16'd5, 32'h11223344, 4'b1111, lat, rdy_after, rd, er, vld_after, er_after);
        txn(1'b1, 16'd5, 32'hAABBCCDD, 4'b0101, lat, rdy_after, rd, er, vld_after, er_after);
        check("wstrb_latency", lat, 2);
        txn(1'b0, 16'd5, 32'd0, 4'b0000, lat, rdy_after, rd, er, vld_after, er_after);
        check("wstrb_merge", rd, 32'h11BB33DD);
        txn(1'b1, 16'd5, 32'hFFFFFFFF, 4'b0000, lat, rdy_after, rd, er, vld_after, er_after);
        check("wstrb0_resp", lat, 2);
        txn(1'b0, 16'd5, 32'd0, 4'b1111, lat, rdy_after, rd, er, vld_after, er_after);
        check("wstrb0_unchanged", rd, 32'h11BB33DD);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end
endmodule
